// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the rriscv core: sequences fetch/decode/execute/memory/writeback,
// raises illegal-instruction and handshake-timeout traps, and counts retired instructions.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  opcode_i,
  input  logic [6:0]  funct7_i,
  input  logic        dec_err_i,
  input  logic        alu_zero_i,
  input  logic        mem_ready_i,
  input  logic        mul_done_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        alu_src_b_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        mul_start_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o,
  output logic [31:0] instret_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC     = 4'd2;
  localparam logic [3:0] S_MEM      = 4'd3;
  localparam logic [3:0] S_WB       = 4'd4;
  localparam logic [3:0] S_MUL_WAIT = 4'd5;
  localparam logic [3:0] S_JUMP     = 4'd6;
  localparam logic [3:0] S_BRANCH   = 4'd7;
  localparam logic [3:0] S_TRAP     = 4'd8;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_MEM_TO  = 2'b10;
  localparam logic [1:0] CAUSE_MUL_TO  = 2'b11;

  // Last wait count still tolerated; a further miss on this count traps.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [3:0]  state_q, state_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [31:0] instret_q, instret_d;
  logic [1:0]  cause_q, cause_d;
  logic        mul_iss_q, mul_iss_d;
  logic        waiting;

  logic is_r, is_mul, is_lw, is_sw;
  assign is_r   = (opcode_i == OP_R);
  assign is_mul = is_r && (funct7_i == F7_MUL);
  assign is_lw  = (opcode_i == OP_LW);
  assign is_sw  = (opcode_i == OP_SW);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    waiting = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i) state_d = S_DECODE;
        else             waiting = 1'b1;
      end
      S_DECODE: begin
        if (dec_err_i) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          case (opcode_i)
            OP_R:                state_d = is_mul ? S_MUL_WAIT : S_EXEC;
            OP_I, OP_LW, OP_SW:  state_d = S_EXEC;
            OP_JAL:              state_d = S_JUMP;
            OP_BR:               state_d = S_BRANCH;
            default: begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          endcase
        end
      end
      S_EXEC:   state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready_i) state_d = is_sw ? S_FETCH : S_WB;
        else             waiting = 1'b1;
      end
      S_MUL_WAIT: begin
        if (mul_done_i) state_d = S_WB;
        else            waiting = 1'b1;
      end
      S_WB, S_JUMP, S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase

    // A handshake arriving on the limit cycle clears 'waiting', so it wins over the trap.
    if (waiting && (to_cnt_q == TO_LAST)) begin
      state_d = S_TRAP;
      cause_d = (state_q == S_MUL_WAIT) ? CAUSE_MUL_TO : CAUSE_MEM_TO;
    end
  end

  always_comb begin
    if (state_d != state_q) to_cnt_d = '0;
    else if (waiting)       to_cnt_d = to_cnt_q + 16'd1;
    else                    to_cnt_d = to_cnt_q;
  end

  assign mul_iss_d = (state_q == S_MUL_WAIT) && (state_d == S_MUL_WAIT);
  assign instret_d = instret_q + {31'b0, pc_we_o};

  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    pc_sel_o       = 2'b00;
    alu_src_b_o    = 1'b0;
    rf_we_o        = 1'b0;
    wb_sel_o       = 2'b00;
    mul_start_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        ir_we_o   = mem_ready_i;
      end
      S_EXEC: alu_src_b_o = !is_r;
      S_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        alu_src_b_o    = 1'b1;
        mem_we_o       = is_sw;
        pc_we_o        = is_sw && mem_ready_i;
      end
      S_WB: begin
        rf_we_o     = 1'b1;
        pc_we_o     = 1'b1;
        alu_src_b_o = !is_r;
        if (is_lw)       wb_sel_o = 2'b01;
        else if (is_mul) wb_sel_o = 2'b11;
        else             wb_sel_o = 2'b00;
      end
      S_MUL_WAIT: mul_start_o = !mul_iss_q;
      S_JUMP: begin
        rf_we_o  = 1'b1;
        wb_sel_o = 2'b10;
        pc_we_o  = 1'b1;
        pc_sel_o = 2'b10;
      end
      S_BRANCH: begin
        pc_we_o  = 1'b1;
        pc_sel_o = alu_zero_i ? 2'b00 : 2'b01;
      end
      default: ;
    endcase
  end

  assign trap_o       = (state_q == S_TRAP);
  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      to_cnt_q  <= '0;
      instret_q <= '0;
      cause_q   <= CAUSE_NONE;
      mul_iss_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
      mul_iss_q <= mul_iss_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction latencies, strobes, traps and timeouts.
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_t;
  logic [6:0]  opcode, funct7;
  logic        dec_err, alu_zero, mem_ready, mem_ready_t, mul_done;

  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_src_b, rf_we, mul_start, trap;
  logic [1:0]  pc_sel, wb_sel, trap_cause;
  logic [31:0] instret;

  logic        mem_req_t, mem_we_t, mem_addr_sel_t, ir_we_t, pc_we_t, alu_src_b_t, rf_we_t;
  logic        mul_start_t, trap_t;
  logic [1:0]  pc_sel_t, wb_sel_t, trap_cause_t;
  logic [31:0] instret_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instret;

  int         r_cycles, r_dreq, r_memwe, r_mulst;
  logic [1:0] r_pc_sel, r_wb_sel;
  logic       r_rf_we, r_alu_b, r_trap;

  multicycle_controller dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct7_i(funct7), .dec_err_i(dec_err),
    .alu_zero_i(alu_zero), .mem_ready_i(mem_ready), .mul_done_i(mul_done),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_sel_o(mem_addr_sel), .ir_we_o(ir_we),
    .pc_we_o(pc_we), .pc_sel_o(pc_sel), .alu_src_b_o(alu_src_b), .rf_we_o(rf_we),
    .wb_sel_o(wb_sel), .mul_start_o(mul_start), .trap_o(trap), .trap_cause_o(trap_cause),
    .instret_o(instret)
  );

  multicycle_controller #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_i(rst_t), .opcode_i(opcode), .funct7_i(funct7), .dec_err_i(dec_err),
    .alu_zero_i(alu_zero), .mem_ready_i(mem_ready_t), .mul_done_i(mul_done),
    .mem_req_o(mem_req_t), .mem_we_o(mem_we_t), .mem_addr_sel_o(mem_addr_sel_t),
    .ir_we_o(ir_we_t), .pc_we_o(pc_we_t), .pc_sel_o(pc_sel_t), .alu_src_b_o(alu_src_b_t),
    .rf_we_o(rf_we_t), .wb_sel_o(wb_sel_t), .mul_start_o(mul_start_t), .trap_o(trap_t),
    .trap_cause_o(trap_cause_t), .instret_o(instret_t)
  );

  // Runs one instruction from its first FETCH cycle until retire or trap, playing memory and
  // multiplier with the given wait counts; entered and left at posedge+1.
  task automatic run_instr(input logic [6:0] opc, input logic [6:0] f7, input logic zero,
                           input logic derr, input int fwait, input int dwait, input int mwait);
    int fcnt, dcnt, mcnt;
    logic rdy, done;
    opcode = opc; funct7 = f7; alu_zero = zero; dec_err = derr;
    fcnt = 0; dcnt = 0; mcnt = -1; done = 1'b0;
    r_cycles = 0; r_dreq = 0; r_memwe = 0; r_mulst = 0;
    r_pc_sel = 2'bxx; r_wb_sel = 2'bxx; r_rf_we = 1'bx; r_alu_b = 1'bx; r_trap = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (mcnt >= 0) mcnt++;
      mul_done = (mcnt > 0) && (mcnt >= mwait);
      rdy = 1'b0;
      if (mem_req && !mem_addr_sel) rdy = (fcnt >= fwait);
      if (mem_req && mem_addr_sel)  rdy = (dcnt >= dwait);
      mem_ready = rdy;
      @(negedge clk);
      r_cycles++;
      if (mem_req && !mem_addr_sel && !rdy) fcnt++;
      if (mem_req && mem_addr_sel) begin
        r_dreq++;
        if (!rdy) dcnt++;
      end
      if (mem_we) r_memwe++;
      if (mul_start) begin
        r_mulst++;
        mcnt = 0;
      end
      if (trap) r_trap = 1'b1;
      if (pc_we) begin
        r_pc_sel = pc_sel; r_wb_sel = wb_sel; r_rf_we = rf_we; r_alu_b = alu_src_b;
      end
      done = pc_we || trap;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; mul_done = 1'b0; dec_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b want 0", trap); end
    checks++; if (trap_cause !== 2'b00) begin errors++; $display("FAIL reset_cause got %b want 00", trap_cause); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
    checks++; if ({mem_req, ir_we, pc_we, rf_we, mem_we, mul_start} !== 6'b100000) begin
      errors++; $display("FAIL reset_strobes got %b want 100000", {mem_req, ir_we, pc_we, rf_we, mem_we, mul_start});
    end
    @(posedge clk); #1;
    exp_instret = 32'd0;
  endtask

  task automatic test_addi();
    run_instr(7'h13, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    exp_instret++;
    checks++; if (r_cycles !== 4) begin errors++; $display("FAIL addi_cycles got %0d want 4", r_cycles); end
    checks++; if ({r_rf_we, r_alu_b} !== 2'b11) begin errors++; $display("FAIL addi_wb got rf/alub=%b want 11", {r_rf_we, r_alu_b}); end
    checks++; if ({r_pc_sel, r_wb_sel} !== 4'b0000) begin errors++; $display("FAIL addi_sel got %b want 0000", {r_pc_sel, r_wb_sel}); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL addi_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_lw_sw();
    run_instr(7'h03, 7'h00, 1'b0, 1'b0, 0, 3, 0);
    exp_instret++;
    checks++; if (r_cycles !== 8) begin errors++; $display("FAIL lw_cycles got %0d want 8", r_cycles); end
    checks++; if (r_dreq !== 4) begin errors++; $display("FAIL lw_memreq got %0d want 4", r_dreq); end
    checks++; if ({r_rf_we, r_wb_sel} !== 3'b101) begin errors++; $display("FAIL lw_wb got %b want 101", {r_rf_we, r_wb_sel}); end
    checks++; if (r_memwe !== 0) begin errors++; $display("FAIL lw_memwe got %0d want 0", r_memwe); end
    run_instr(7'h23, 7'h00, 1'b0, 1'b0, 0, 3, 0);
    exp_instret++;
    checks++; if (r_cycles !== 7) begin errors++; $display("FAIL sw_cycles got %0d want 7", r_cycles); end
    checks++; if (r_dreq !== 4) begin errors++; $display("FAIL sw_memreq got %0d want 4", r_dreq); end
    checks++; if (r_memwe !== 4) begin errors++; $display("FAIL sw_memwe got %0d want 4", r_memwe); end
    checks++; if ({r_rf_we, r_pc_sel} !== 3'b000) begin errors++; $display("FAIL sw_retire got %b want 000", {r_rf_we, r_pc_sel}); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL lwsw_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_branch_jump();
    run_instr(7'h63, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    exp_instret++;
    checks++; if (r_cycles !== 3) begin errors++; $display("FAIL bne_taken_cycles got %0d want 3", r_cycles); end
    checks++; if ({r_rf_we, r_alu_b, r_pc_sel} !== 4'b0001) begin errors++; $display("FAIL bne_taken got %b want 0001", {r_rf_we, r_alu_b, r_pc_sel}); end
    run_instr(7'h63, 7'h00, 1'b1, 1'b0, 0, 0, 0);
    exp_instret++;
    checks++; if (r_cycles !== 3) begin errors++; $display("FAIL bne_nt_cycles got %0d want 3", r_cycles); end
    checks++; if (r_pc_sel !== 2'b00) begin errors++; $display("FAIL bne_nt_pcsel got %b want 00", r_pc_sel); end
    run_instr(7'h6F, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    exp_instret++;
    checks++; if (r_cycles !== 3) begin errors++; $display("FAIL jal_cycles got %0d want 3", r_cycles); end
    checks++; if ({r_rf_we, r_wb_sel, r_pc_sel} !== 5'b11010) begin errors++; $display("FAIL jal_strobes got %b want 11010", {r_rf_we, r_wb_sel, r_pc_sel}); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL bj_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_back_to_back();
    run_instr(7'h33, 7'h01, 1'b0, 1'b0, 0, 0, 6);
    exp_instret++;
    checks++; if (r_cycles !== 10) begin errors++; $display("FAIL mul_cycles got %0d want 10", r_cycles); end
    checks++; if (r_mulst !== 1) begin errors++; $display("FAIL mul_start_pulses got %0d want 1", r_mulst); end
    checks++; if ({r_rf_we, r_wb_sel} !== 3'b111) begin errors++; $display("FAIL mul_wb got %b want 111", {r_rf_we, r_wb_sel}); end
    run_instr(7'h33, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    exp_instret++;
    checks++; if (r_cycles !== 4) begin errors++; $display("FAIL add_cycles got %0d want 4", r_cycles); end
    checks++; if ({r_mulst[0], r_alu_b, r_wb_sel} !== 4'b0000) begin errors++; $display("FAIL add_strobes got %b want 0000", {r_mulst[0], r_alu_b, r_wb_sel}); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL mul_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_illegal(input logic [6:0] opc, input logic derr, input string tag);
    run_instr(opc, 7'h00, 1'b0, derr, 0, 0, 0);
    checks++; if (r_trap !== 1'b1 || r_cycles !== 3) begin errors++; $display("FAIL %s_trap got trap=%b cycles=%0d want 1/3", tag, r_trap, r_cycles); end
    checks++; if (trap_cause !== 2'b01) begin errors++; $display("FAIL %s_cause got %b want 01", tag, trap_cause); end
    for (int k = 0; k < 4; k++) begin
      mem_ready = k[0]; mul_done = 1'b1; opcode = 7'h33; funct7 = 7'h01;
      @(negedge clk);
      checks++; if ({trap, mem_req, ir_we, pc_we, rf_we, mem_we, mul_start} !== 7'b1000000) begin
        errors++; $display("FAIL %s_hold got %b want 1000000", tag, {trap, mem_req, ir_we, pc_we, rf_we, mem_we, mul_start});
      end
      checks++; if (instret !== exp_instret) begin errors++; $display("FAIL %s_instret got %0d want %0d", tag, instret, exp_instret); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; mul_done = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = 32'd0;
    @(negedge clk);
    checks++; if ({trap, trap_cause, mem_req} !== 4'b0001) begin errors++; $display("FAIL %s_reset got %b want 0001", tag, {trap, trap_cause, mem_req}); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL %s_reset_instret got %0d want 0", tag, instret); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    mem_ready_t = 1'b0;
    rst_t = 1'b1;
    @(posedge clk); #1;
    rst_t = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if ({trap_t, mem_req_t} !== 2'b01) begin errors++; $display("FAIL to_wait%0d got %b want 01", k, {trap_t, mem_req_t}); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if ({trap_t, trap_cause_t, mem_req_t} !== 4'b1100) begin errors++; $display("FAIL to_trap got %b want 1100", {trap_t, trap_cause_t, mem_req_t}); end
    @(posedge clk); #1;
    rst_t = 1'b1;
    @(posedge clk); #1;
    rst_t = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mem_ready_t = (k == 4);
      @(negedge clk);
      checks++; if ({trap_t, ir_we_t} !== {1'b0, (k == 4)}) begin errors++; $display("FAIL to_limit%0d got %b want 0%b", k, {trap_t, ir_we_t}, (k == 4)); end
      @(posedge clk); #1;
    end
    mem_ready_t = 1'b0;
    @(negedge clk);
    checks++; if ({trap_t, trap_cause_t, mem_req_t} !== 4'b0000) begin errors++; $display("FAIL to_limit_decode got %b want 0000", {trap_t, trap_cause_t, mem_req_t}); end
    @(posedge clk); #1;
    rst_t = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rst_t = 1'b1;
    opcode = 7'h00; funct7 = 7'h00; dec_err = 1'b0; alu_zero = 1'b0;
    mem_ready = 1'b0; mem_ready_t = 1'b0; mul_done = 1'b0;
    exp_instret = 32'd0;
    test_reset();
    test_addi();
    test_lw_sw();
    test_branch_jump();
    test_back_to_back();
    test_illegal(7'h7F, 1'b0, "illegal_op");
    test_illegal(7'h13, 1'b1, "dec_err");
    test_addi();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
